// File: rtl/tag_store_pkg.sv
// Shared command/state encodings and width helpers for the indexed tag store.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tag_store_pkg;

    localparam int TS_DATA_W = 32;

    typedef enum logic [2:0] {
        TS_NOP   = 3'd0,
        TS_ALLOC = 3'd1,
        TS_READ  = 3'd2,
        TS_FREE  = 3'd3,
        TS_FLUSH = 3'd4
    } TS_CMD;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } ts_state_e;

    // Index width for a table of 'size' entries; never below one bit.
    function automatic int ts_idx_w(input int size);
        return (size > 2) ? $clog2(size) : 1;
    endfunction

endpackage

// File: rtl/tag_store_if.sv
// Request/response bundle between a requester and the tag store.
// Latency: n/a (wiring only).
// Backpressure: req_ready gates acceptance of req_valid.
interface tag_store_if
    import tag_store_pkg::*;
#(
    parameter int SIZE = 8
);
    localparam int IDX_W = ts_idx_w(SIZE);
    localparam int CNT_W = $clog2(SIZE + 1);

    logic                 req_valid;
    logic                 req_ready;
    TS_CMD                req_cmd;
    logic [TS_DATA_W-1:0] req_data;
    logic [IDX_W-1:0]     req_idx;

    logic                 rsp_valid;
    logic                 rsp_ok;
    logic [IDX_W-1:0]     rsp_idx;
    logic [TS_DATA_W-1:0] rsp_data;

    logic [CNT_W-1:0]     count;
    logic                 full;
    logic                 empty;

    modport master (
        output req_valid, req_cmd, req_data, req_idx,
        input  req_ready, rsp_valid, rsp_ok, rsp_idx, rsp_data, count, full, empty
    );

    modport slave (
        input  req_valid, req_cmd, req_data, req_idx,
        output req_ready, rsp_valid, rsp_ok, rsp_idx, rsp_data, count, full, empty
    );

endinterface

// File: rtl/tag_store_first_free.sv
// Lowest-index free-slot priority encoder over the valid bitmap.
// Latency: purely combinational.
// Backpressure: none; o_any=0 tells the caller the table is full.
module ts_first_free
    import tag_store_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic [SIZE-1:0]           i_valid,
    output logic [ts_idx_w(SIZE)-1:0] o_idx,
    output logic                      o_any
);
    localparam int IDX_W = ts_idx_w(SIZE);

    // Scan from the top down so the lowest free index is the last one written.
    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (!i_valid[i]) begin
                o_idx = IDX_W'(i);
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tag_store.sv
// Indexed tag table: ALLOC by value returns a slot, READ/FREE by index, FLUSH clears all.
// Latency: ALLOC/READ/FREE respond one cycle after acceptance; FLUSH responds SIZE+1 cycles after.
// Backpressure: req_ready drops for the SIZE cycles of a flush walk, otherwise always ready.
module tag_store
    import tag_store_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    tag_store_if.slave  io_bus
);
    localparam int IDX_W = ts_idx_w(SIZE);
    localparam int CNT_W = $clog2(SIZE + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SIZE);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    ts_state_e            r_state;
    ts_state_e            w_state_nxt;
    logic [TS_DATA_W-1:0] r_mem [SIZE];
    logic [SIZE-1:0]      r_valid;
    logic [CNT_W-1:0]     r_count;
    logic [IDX_W-1:0]     r_ptr;

    logic                 r_rsp_valid;
    logic                 r_rsp_ok;
    logic [IDX_W-1:0]     r_rsp_idx;
    logic [TS_DATA_W-1:0] r_rsp_data;

    logic                 w_ready;
    logic                 w_accept;
    logic                 w_idx_in_range;
    logic                 w_slot_valid;
    logic                 w_free_any;
    logic [IDX_W-1:0]     w_free_idx;
    logic                 w_do_alloc;
    logic                 w_do_free;
    logic                 w_flush_dec;

    ts_first_free #(.SIZE(SIZE)) u_first_free (
        .i_valid (r_valid),
        .o_idx   (w_free_idx),
        .o_any   (w_free_any)
    );

    assign w_ready        = (r_state == ST_IDLE);
    assign w_accept       = io_bus.req_valid && w_ready;
    // Non-power-of-two tables can see indices past the end; they never reach storage.
    assign w_idx_in_range = (32'(io_bus.req_idx) < 32'(SIZE));
    assign w_slot_valid   = w_idx_in_range && r_valid[io_bus.req_idx];
    assign w_do_alloc     = w_accept && (io_bus.req_cmd == TS_ALLOC) && w_free_any;
    assign w_do_free      = w_accept && (io_bus.req_cmd == TS_FREE) && w_slot_valid;
    assign w_flush_dec    = (r_state == ST_FLUSH) && r_valid[r_ptr];

    // State register.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= ST_IDLE;
        else            r_state <= w_state_nxt;
    end

    // Next state: a flush walks every slot once, then drops back to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept && (io_bus.req_cmd == TS_FLUSH)) w_state_nxt = ST_FLUSH;
            ST_FLUSH: if (r_ptr == LAST_IDX) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Data storage has no reset; only the valid bitmap defines occupancy.
    always_ff @(posedge i_clock) begin
        if (w_do_alloc) r_mem[w_free_idx] <= io_bus.req_data;
    end

    // Valid bitmap, occupancy count and flush pointer; alloc/free and flush never overlap.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_valid <= '0;
            r_count <= '0;
            r_ptr   <= '0;
        end else begin
            if (w_do_alloc) begin
                r_valid[w_free_idx] <= 1'b1;
                r_count             <= r_count + CNT_ONE;
            end
            if (w_do_free) begin
                r_valid[io_bus.req_idx] <= 1'b0;
                r_count                 <= r_count - CNT_ONE;
            end
            if (w_accept && (io_bus.req_cmd == TS_FLUSH)) begin
                r_ptr <= '0;
            end
            if (r_state == ST_FLUSH) begin
                r_valid[r_ptr] <= 1'b0;
                if (w_flush_dec) r_count <= r_count - CNT_ONE;
                if (r_ptr != LAST_IDX) r_ptr <= r_ptr + IDX_W'(1);
            end
        end
    end

    // Response registers: a single pulse per request, fields zero when idle.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_ok    <= 1'b0;
            r_rsp_idx   <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_ok    <= 1'b0;
            r_rsp_idx   <= '0;
            r_rsp_data  <= '0;
            if (r_state == ST_FLUSH) begin
                if (r_ptr == LAST_IDX) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_ok    <= 1'b1;
                    r_rsp_idx   <= LAST_IDX;
                end
            end else if (w_accept) begin
                case (io_bus.req_cmd)
                    TS_ALLOC: begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_ok    <= w_free_any;
                        r_rsp_idx   <= w_free_any ? w_free_idx : '0;
                    end
                    TS_READ: begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_ok    <= w_slot_valid;
                        r_rsp_idx   <= io_bus.req_idx;
                        r_rsp_data  <= w_slot_valid ? r_mem[io_bus.req_idx] : '0;
                    end
                    TS_FREE: begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_ok    <= w_slot_valid;
                        r_rsp_idx   <= io_bus.req_idx;
                    end
                    default: begin
                        r_rsp_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign io_bus.req_ready = w_ready;
    assign io_bus.rsp_valid = r_rsp_valid;
    assign io_bus.rsp_ok    = r_rsp_ok;
    assign io_bus.rsp_idx   = r_rsp_idx;
    assign io_bus.rsp_data  = r_rsp_data;
    assign io_bus.count     = r_count;
    assign io_bus.full      = (r_count == CNT_FULL);
    assign io_bus.empty     = (r_count == '0);

endmodule

// File: tb/tb_tag_store.sv
// Bench for tag_store: directed scenarios on SIZE=8 and SIZE=5 plus randomized traffic.
// Expected responses come from a transaction-level reference model through a scoreboard queue.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_tag_store;
    import tag_store_pkg::*;

    logic clk = 1'b0;
    logic rst8_n;
    logic rst5_n;
    always #5 clk = ~clk;

    tag_store_if #(.SIZE(8)) if8 ();
    tag_store_if #(.SIZE(5)) if5 ();

    tag_store #(.SIZE(8)) dut8 (.i_clock(clk), .i_reset_n(rst8_n), .io_bus(if8.slave));
    tag_store #(.SIZE(5)) dut5 (.i_clock(clk), .i_reset_n(rst5_n), .io_bus(if5.slave));

    typedef struct {
        logic        ok;
        int          idx;
        logic [31:0] data;
    } rsp_t;

    rsp_t sb_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int          sel;
    int          msize;
    bit          m_valid [8];
    logic [31:0] m_mem   [8];
    int          m_count;
    bit          m_flushing;
    int          m_ptr;

    // Last observations, for scenario-level checks against constants
    logic        last_rdy;
    logic        last_got;
    logic        last_ok;
    int          last_idx;
    logic [31:0] last_data;

    task automatic model_reset(input int size);
        msize = size;
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        m_count    = 0;
        m_flushing = 1'b0;
        m_ptr      = 0;
        sb_q.delete();
    endtask

    // One clock cycle on the selected DUT: drive, advance the model, check after the edge.
    task automatic step(input bit v, input TS_CMD c, input logic [31:0] d, input int idx);
        bit          due;
        bit          found;
        rsp_t        e;
        logic        o_rdy, o_v, o_ok, o_full, o_empty;
        int          o_idx, o_cnt;
        logic [31:0] o_data;
        if (sel == 8) begin
            if8.req_valid = v; if8.req_cmd = c; if8.req_data = d; if8.req_idx = 3'(idx);
            if5.req_valid = 1'b0;
            o_rdy = if8.req_ready;
        end else begin
            if5.req_valid = v; if5.req_cmd = c; if5.req_data = d; if5.req_idx = 3'(idx);
            if8.req_valid = 1'b0;
            o_rdy = if5.req_ready;
        end
        last_rdy = o_rdy;
        n_checks++;
        if (o_rdy !== !m_flushing) $display("FAIL req_ready: got %b want %b", o_rdy, !m_flushing);
        else n_pass++;

        due = 1'b0;
        if (m_flushing) begin
            if (m_valid[m_ptr]) m_count--;
            m_valid[m_ptr] = 1'b0;
            if (m_ptr == msize - 1) begin
                m_flushing = 1'b0;
                e.ok = 1'b1; e.idx = msize - 1; e.data = 32'h0;
                sb_q.push_back(e); due = 1'b1;
            end else begin
                m_ptr++;
            end
        end else if (v) begin
            case (c)
                TS_ALLOC: begin
                    found = 1'b0;
                    e.ok = 1'b0; e.idx = 0; e.data = 32'h0;
                    for (int i = 0; i < msize; i++) begin
                        if (!found && !m_valid[i]) begin
                            found = 1'b1; m_valid[i] = 1'b1; m_mem[i] = d; m_count++;
                            e.ok = 1'b1; e.idx = i;
                        end
                    end
                    sb_q.push_back(e); due = 1'b1;
                end
                TS_READ: begin
                    e.ok   = (idx < msize) && m_valid[idx];
                    e.idx  = idx;
                    e.data = e.ok ? m_mem[idx] : 32'h0;
                    sb_q.push_back(e); due = 1'b1;
                end
                TS_FREE: begin
                    e.ok = (idx < msize) && m_valid[idx];
                    e.idx = idx; e.data = 32'h0;
                    if (e.ok) begin m_valid[idx] = 1'b0; m_count--; end
                    sb_q.push_back(e); due = 1'b1;
                end
                TS_FLUSH: begin m_flushing = 1'b1; m_ptr = 0; end
                default: ;
            endcase
        end

        @(posedge clk);
        @(negedge clk);
        if (sel == 8) begin
            o_v = if8.rsp_valid; o_ok = if8.rsp_ok; o_idx = int'(if8.rsp_idx); o_data = if8.rsp_data;
            o_cnt = int'(if8.count); o_full = if8.full; o_empty = if8.empty;
        end else begin
            o_v = if5.rsp_valid; o_ok = if5.rsp_ok; o_idx = int'(if5.rsp_idx); o_data = if5.rsp_data;
            o_cnt = int'(if5.count); o_full = if5.full; o_empty = if5.empty;
        end
        last_got = o_v;
        n_checks++;
        if (o_v !== due) $display("FAIL rsp_valid: got %b want %b", o_v, due);
        else n_pass++;
        if (o_v === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL rsp_unexpected: got a response, want none queued");
            end else begin
                e = sb_q.pop_front();
                last_ok = o_ok; last_idx = o_idx; last_data = o_data;
                n_checks++;
                if (o_ok !== e.ok) $display("FAIL rsp_ok: got %b want %b", o_ok, e.ok); else n_pass++;
                n_checks++;
                if (o_idx !== e.idx) $display("FAIL rsp_idx: got %0d want %0d", o_idx, e.idx); else n_pass++;
                n_checks++;
                if (o_data !== e.data) $display("FAIL rsp_data: got %h want %h", o_data, e.data); else n_pass++;
            end
        end else if (due) begin
            e = sb_q.pop_front();
        end
        n_checks++;
        if (o_cnt !== m_count) $display("FAIL count: got %0d want %0d", o_cnt, m_count); else n_pass++;
        n_checks++;
        if (o_full !== (m_count == msize)) $display("FAIL full: got %b want %b", o_full, m_count == msize); else n_pass++;
        n_checks++;
        if (o_empty !== (m_count == 0)) $display("FAIL empty: got %b want %b", o_empty, m_count == 0); else n_pass++;
    endtask

    task automatic test_reset();
        if8.req_valid = 1'b0; if8.req_cmd = TS_NOP; if8.req_data = '0; if8.req_idx = '0;
        if5.req_valid = 1'b0; if5.req_cmd = TS_NOP; if5.req_data = '0; if5.req_idx = '0;
        rst8_n = 1'b0; rst5_n = 1'b0;
        #1;
        n_checks++;
        if ({if8.rsp_valid, if8.rsp_ok, if8.rsp_idx, if8.rsp_data} !== '0)
            $display("FAIL reset_rsp: got v=%b ok=%b idx=%0d data=%h want all 0",
                     if8.rsp_valid, if8.rsp_ok, if8.rsp_idx, if8.rsp_data);
        else n_pass++;
        n_checks++;
        if (if8.count !== 4'd0 || if8.empty !== 1'b1 || if8.full !== 1'b0)
            $display("FAIL reset_occ: got count=%0d empty=%b full=%b want 0/1/0", if8.count, if8.empty, if8.full);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst8_n = 1'b1; rst5_n = 1'b1;
        #1;
        n_checks++;
        if (if8.req_ready !== 1'b1 || if5.req_ready !== 1'b1)
            $display("FAIL reset_ready: got %b/%b want 1/1", if8.req_ready, if5.req_ready);
        else n_pass++;
        @(negedge clk);
        sel = 8;
        model_reset(8);
    endtask

    task automatic test_alloc();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, TS_ALLOC, 32'hA0 + i, 0);
            n_checks++;
            if (last_got !== 1'b1 || last_ok !== 1'b1 || last_idx !== i)
                $display("FAIL alloc_first: got v=%b ok=%b idx=%0d want v=1 ok=1 idx=%0d", last_got, last_ok, last_idx, i);
            else n_pass++;
        end
        n_checks++;
        if (if8.count !== 4'd3 || if8.empty !== 1'b0)
            $display("FAIL alloc_count: got count=%0d empty=%b want 3/0", if8.count, if8.empty);
        else n_pass++;
    endtask

    task automatic test_free_reuse();
        step(1'b1, TS_FREE, 32'h0, 1);
        n_checks++;
        if (last_ok !== 1'b1) $display("FAIL free_ok: got %b want 1", last_ok); else n_pass++;
        step(1'b1, TS_ALLOC, 32'hB1, 0);
        n_checks++;
        if (last_idx !== 1) $display("FAIL alloc_reuse: got idx=%0d want 1", last_idx); else n_pass++;
        step(1'b1, TS_READ, 32'h0, 1);
        n_checks++;
        if (last_ok !== 1'b1 || last_data !== 32'hB1)
            $display("FAIL read_back: got ok=%b data=%h want 1/000000b1", last_ok, last_data);
        else n_pass++;
        step(1'b1, TS_FREE, 32'h0, 1);
        step(1'b1, TS_FREE, 32'h0, 1);
        n_checks++;
        if (last_ok !== 1'b0 || last_idx !== 1)
            $display("FAIL double_free: got ok=%b idx=%0d want 0/1", last_ok, last_idx);
        else n_pass++;
    endtask

    task automatic test_flush();
        int lows;
        bit got;
        step(1'b1, TS_ALLOC, 32'hC3, 0);   // back to 3 valid entries
        step(1'b1, TS_FLUSH, 32'h0, 0);
        lows = 0; got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            step(1'b0, TS_NOP, 32'h0, 0);
            if (last_rdy === 1'b0) lows++;
            if (last_got === 1'b1) got = 1'b1;
        end
        n_checks++;
        if (!got) $display("FAIL flush_timeout: got no response in 20 cycles, want one"); else n_pass++;
        n_checks++;
        if (lows !== 8) $display("FAIL flush_busy: got %0d not-ready cycles want 8", lows); else n_pass++;
        n_checks++;
        if (last_ok !== 1'b1 || last_idx !== 7)
            $display("FAIL flush_rsp: got ok=%b idx=%0d want 1/7", last_ok, last_idx);
        else n_pass++;
        n_checks++;
        if (if8.count !== 4'd0 || if8.empty !== 1'b1)
            $display("FAIL flush_occ: got count=%0d empty=%b want 0/1", if8.count, if8.empty);
        else n_pass++;
        step(1'b1, TS_READ, 32'h0, 0);
        n_checks++;
        if (last_rdy !== 1'b1 || last_ok !== 1'b0)
            $display("FAIL flush_read: got rdy=%b ok=%b want 1/0", last_rdy, last_ok);
        else n_pass++;
    endtask

    task automatic test_reset_in_flush();
        for (int i = 0; i < 3; i++) step(1'b1, TS_ALLOC, 32'hD0 + i, 0);
        step(1'b1, TS_FLUSH, 32'h0, 0);
        step(1'b0, TS_NOP, 32'h0, 0);
        step(1'b0, TS_NOP, 32'h0, 0);
        if8.req_valid = 1'b0;
        rst8_n = 1'b0;
        #1;
        n_checks++;
        if ({if8.rsp_valid, if8.rsp_ok, if8.rsp_idx, if8.rsp_data} !== '0 || if8.count !== 4'd0 ||
            if8.empty !== 1'b1 || if8.full !== 1'b0)
            $display("FAIL abort_reset: got v=%b cnt=%0d empty=%b full=%b want 0/0/1/0",
                     if8.rsp_valid, if8.count, if8.empty, if8.full);
        else n_pass++;
        @(negedge clk);
        rst8_n = 1'b1;
        model_reset(8);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            n_checks++;
            if (if8.rsp_valid !== 1'b0 || if8.req_ready !== 1'b1)
                $display("FAIL abort_quiet: got v=%b rdy=%b want 0/1", if8.rsp_valid, if8.req_ready);
            else n_pass++;
        end
        step(1'b1, TS_ALLOC, 32'hE0, 0);
        n_checks++;
        if (last_ok !== 1'b1 || last_idx !== 0)
            $display("FAIL abort_alloc: got ok=%b idx=%0d want 1/0", last_ok, last_idx);
        else n_pass++;
    endtask

    task automatic test_size5();
        sel = 5;
        model_reset(5);
        for (int i = 0; i < 5; i++) step(1'b1, TS_ALLOC, 32'h50 + i, 0);
        n_checks++;
        if (if5.full !== 1'b1 || if5.count !== 3'd5)
            $display("FAIL s5_full: got full=%b count=%0d want 1/5", if5.full, if5.count);
        else n_pass++;
        step(1'b1, TS_ALLOC, 32'h55, 0);
        n_checks++;
        if (last_ok !== 1'b0 || last_idx !== 0)
            $display("FAIL s5_overflow: got ok=%b idx=%0d want 0/0", last_ok, last_idx);
        else n_pass++;
        step(1'b1, TS_READ, 32'h0, 6);
        n_checks++;
        if (last_ok !== 1'b0 || last_data !== 32'h0 || last_idx !== 6)
            $display("FAIL s5_read_oor: got ok=%b data=%h idx=%0d want 0/0/6", last_ok, last_data, last_idx);
        else n_pass++;
        step(1'b1, TS_FREE, 32'h0, 7);
        n_checks++;
        if (last_ok !== 1'b0 || if5.count !== 3'd5)
            $display("FAIL s5_free_oor: got ok=%b count=%0d want 0/5", last_ok, if5.count);
        else n_pass++;
    endtask

    task automatic test_random(input int which, input int n);
        int    r;
        TS_CMD c;
        sel = which;
        for (int k = 0; k < n; k++) begin
            r = $urandom_range(0, 31);
            if (r == 0)       c = TS_FLUSH;
            else if (r < 3)   c = TS_NOP;
            else if (r < 14)  c = TS_ALLOC;
            else if (r < 23)  c = TS_READ;
            else              c = TS_FREE;
            step($urandom_range(0, 3) != 0, c, $urandom, $urandom_range(0, 7));
        end
        for (int k = 0; k < 10; k++) step(1'b0, TS_NOP, 32'h0, 0);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_alloc();
        test_free_reuse();
        test_flush();
        test_reset_in_flush();
        test_random(8, 1000);
        test_size5();
        test_random(5, 300);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
